// File: rtl/dmem_pkg.sv
// Shared types and helpers for the memory-stage controller slice.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      READ
   } dmem_state_e;

   localparam logic [3:0] OP_LW = 4'h8;
   localparam logic [3:0] OP_SW = 4'h9;

   localparam int unsigned ALIGN_W = 64;

   // Callers cast the address up to ALIGN_W bits and the result back down to their own width.
   function automatic logic [ALIGN_W-1:0] word_align(input logic [ALIGN_W-1:0] addr);
      return {addr[ALIGN_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer with an address-match output for store-to-load forwarding.
module dmem_wbuf
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] cmp_addr_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              hit_o
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
         data_d  = data_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;
   assign hit_o   = valid_q && (addr_q == cmp_addr_i);

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage controller: LW/SW to a single-port data memory with a posted write buffer.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter bit          FWD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              stall,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   dmem_state_e       state_q, state_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

   logic              wb_load, wb_clear;
   logic              wb_valid, wb_hit;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [ADDR_W-1:0] req_addr_al;

   assign req_addr_al = ADDR_W'(word_align(ALIGN_W'(req_addr)));

   dmem_wbuf #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_wbuf (
      .clk_i     (clk),
      .rst_i     (rst),
      .load_i    (wb_load),
      .clear_i   (wb_clear),
      .addr_i    (req_addr_al),
      .data_i    (req_wdata),
      .cmp_addr_i(req_addr_al),
      .valid_o   (wb_valid),
      .addr_o    (wb_addr),
      .data_o    (wb_data),
      .hit_o     (wb_hit)
   );

   always_comb begin
      state_d      = state_q;
      mem_en_d     = mem_en_q;
      mem_wr_d     = mem_wr_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      wb_load      = 1'b0;
      wb_clear     = 1'b0;
      req_ready    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_wr) req_ready = !wb_valid;
            else        req_ready = !wb_valid || (FWD_EN && wb_hit);

            if (req_valid && req_ready) begin
               if (req_wr) begin
                  wb_load = 1'b1;
               end else if (wb_valid) begin
                  // Only a forwarding hit can be ready with the buffer occupied; the entry stays queued.
                  resp_valid_d = 1'b1;
                  resp_rdata_d = wb_data;
               end else begin
                  state_d    = READ;
                  mem_en_d   = 1'b1;
                  mem_wr_d   = 1'b0;
                  mem_addr_d = req_addr_al;
               end
            end else if (wb_valid) begin
               state_d     = DRAIN;
               mem_en_d    = 1'b1;
               mem_wr_d    = 1'b1;
               mem_addr_d  = wb_addr;
               mem_wdata_d = wb_data;
            end
         end
         DRAIN: begin
            if (mem_ack) begin
               wb_clear = 1'b1;
               mem_en_d = 1'b0;
               mem_wr_d = 1'b0;
               state_d  = IDLE;
            end
         end
         READ: begin
            if (mem_ack) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = mem_rdata;
               mem_en_d     = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         mem_en_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         mem_en_q     <= mem_en_d;
         mem_wr_q     <= mem_wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign stall      = req_valid && !req_ready;
   assign mem_en     = mem_en_q;
   assign mem_wr     = mem_wr_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed checks of dmem_ctrl: reset, posted stores, forwarding, load misses, drain ordering.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_wr;
   logic [15:0] req_addr, req_wdata;
   logic        req_ready, stall;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(
      .ADDR_W(16),
      .DATA_W(16),
      .FWD_EN(1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .stall     (stall),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic wr, input logic [15:0] addr, input logic [15:0] data);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = data;
      #1;
   endtask

   task automatic idle_req();
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic wait_mem_en(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (mem_en === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s: mem_en never rose within 4 cycles (got %b, expected 1)", name, mem_en);
      end
   endtask

   // Test 1: reset abandons an in-flight read; a late ack is ignored.
   task automatic test_reset();
      rst = 1'b1;
      idle_req();
      mem_ack = 1'b0;
      mem_rdata = '0;
      step();
      step();
      rst = 1'b0;
      #1;
      vectors++;
      if (mem_en !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 16'h0000 || mem_addr !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_outputs: mem_en=%b resp_valid=%b resp_rdata=%h mem_addr=%h, expected 0/0/0000/0000",
                  mem_en, resp_valid, resp_rdata, mem_addr);
      end
      drive_req(1'b0, 16'h0010, 16'h0000);
      vectors++;
      if (req_ready !== 1'b1 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_lw_ready: ready=%b stall=%b, expected 1/0", req_ready, stall);
      end
      step();
      idle_req();
      vectors++;
      if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0010) begin
         miscompares++;
         $display("FAIL reset_read_issue: en=%b wr=%b addr=%h, expected 1/0/0010", mem_en, mem_wr, mem_addr);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++;
      if (mem_en !== 1'b0 || resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_read: mem_en=%b resp_valid=%b, expected 0/0", mem_en, resp_valid);
      end
      mem_ack = 1'b1;
      mem_rdata = 16'hDEAD;
      step();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (resp_valid !== 1'b0 || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_late_ack[%0d]: resp_valid=%b mem_en=%b, expected 0/0", i, resp_valid, mem_en);
         end
         step();
      end
   endtask

   // Test 2: posted store drains with stable memory signals until ack.
   task automatic test_store_drain();
      drive_req(1'b1, 16'h0020, 16'hBEEF);
      vectors++;
      if (req_ready !== 1'b1 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL sw_ready: ready=%b stall=%b, expected 1/0", req_ready, stall);
      end
      step();
      idle_req();
      vectors++;
      if (mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL sw_accept_no_access: mem_en=%b, expected 0", mem_en);
      end
      wait_mem_en("sw_drain_start");
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL sw_drain_hold[%0d]: en=%b wr=%b addr=%h wdata=%h, expected 1/1/0020/BEEF",
                     i, mem_en, mem_wr, mem_addr, mem_wdata);
         end
         if (i == 2) mem_ack = 1'b1;
         step();
      end
      mem_ack = 1'b0;
      #1;
      vectors++;
      if (mem_en !== 1'b0 || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL sw_drain_done: mem_en=%b ready=%b, expected 0/1", mem_en, req_ready);
      end
   endtask

   // Test 3: load to a buffered address (unaligned byte) forwards without a memory read.
   task automatic test_forward();
      drive_req(1'b1, 16'h0040, 16'h1234);
      step();
      drive_req(1'b0, 16'h0041, 16'h0000);
      vectors++;
      if (req_ready !== 1'b1 || stall !== 1'b0 || mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL fwd_accept: ready=%b stall=%b mem_en=%b, expected 1/0/0", req_ready, stall, mem_en);
      end
      step();
      idle_req();
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== 16'h1234 || mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL fwd_resp: valid=%b rdata=%h mem_en=%b, expected 1/1234/0", resp_valid, resp_rdata, mem_en);
      end
      step();
      vectors++;
      if (resp_valid !== 1'b0 || resp_rdata !== 16'h1234 || mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0040) begin
         miscompares++;
         $display("FAIL fwd_then_drain: valid=%b rdata=%h en=%b wr=%b addr=%h, expected 0/1234/1/1/0040",
                  resp_valid, resp_rdata, mem_en, mem_wr, mem_addr);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
   endtask

   // Test 4: load miss with single-cycle ack returns two cycles after accept.
   task automatic test_load_miss();
      drive_req(1'b0, 16'h0100, 16'h0000);
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL miss_ready: ready=%b, expected 1", req_ready);
      end
      step();
      idle_req();
      vectors++;
      if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0100 || resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL miss_issue: en=%b wr=%b addr=%h resp_valid=%b, expected 1/0/0100/0",
                  mem_en, mem_wr, mem_addr, resp_valid);
      end
      mem_ack = 1'b1;
      mem_rdata = 16'hA5A5;
      step();
      mem_ack = 1'b0;
      mem_rdata = 16'h0000;
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== 16'hA5A5 || mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL miss_resp: valid=%b rdata=%h mem_en=%b, expected 1/A5A5/0", resp_valid, resp_rdata, mem_en);
      end
      step();
      vectors++;
      if (resp_valid !== 1'b0 || resp_rdata !== 16'hA5A5) begin
         miscompares++;
         $display("FAIL miss_pulse: valid=%b rdata=%h, expected 0/A5A5", resp_valid, resp_rdata);
      end
   endtask

   // Test 5: load miss behind a buffered store stalls through the drain, then reads.
   task automatic test_drain_then_load();
      drive_req(1'b1, 16'h0002, 16'h5555);
      step();
      drive_req(1'b0, 16'h0004, 16'h0000);
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++;
         $display("FAIL dl_stall_buffered: stall=%b, expected 1", stall);
      end
      wait_mem_en("dl_drain_start");
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (stall !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0002 || mem_wdata !== 16'h5555) begin
            miscompares++;
            $display("FAIL dl_drain[%0d]: stall=%b wr=%b addr=%h wdata=%h, expected 1/1/0002/5555",
                     i, stall, mem_wr, mem_addr, mem_wdata);
         end
         if (i == 1) mem_ack = 1'b1;
         step();
      end
      mem_ack = 1'b0;
      #1;
      vectors++;
      if (stall !== 1'b0 || req_ready !== 1'b1 || mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL dl_accept: stall=%b ready=%b mem_en=%b, expected 0/1/0", stall, req_ready, mem_en);
      end
      step();
      idle_req();
      vectors++;
      if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0004) begin
         miscompares++;
         $display("FAIL dl_read: en=%b wr=%b addr=%h, expected 1/0/0004", mem_en, mem_wr, mem_addr);
      end
      mem_ack = 1'b1;
      mem_rdata = 16'h7777;
      step();
      mem_ack = 1'b0;
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== 16'h7777) begin
         miscompares++;
         $display("FAIL dl_resp: valid=%b rdata=%h, expected 1/7777", resp_valid, resp_rdata);
      end
      step();
   endtask

   // Test 6: second store waits for the first store's ack, then is accepted in IDLE.
   task automatic test_back_to_back();
      drive_req(1'b1, 16'h0006, 16'h1111);
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first_ready: ready=%b, expected 1", req_ready);
      end
      step();
      drive_req(1'b1, 16'h0008, 16'h2222);
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_second_stall: stall=%b, expected 1", stall);
      end
      wait_mem_en("b2b_drain_start");
      vectors++;
      if (stall !== 1'b1 || mem_addr !== 16'h0006 || mem_wdata !== 16'h1111) begin
         miscompares++;
         $display("FAIL b2b_drain1: stall=%b addr=%h wdata=%h, expected 1/0006/1111", stall, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      #1;
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_ack_cycle: stall=%b, expected 1", stall);
      end
      step();
      mem_ack = 1'b0;
      #1;
      vectors++;
      if (stall !== 1'b0 || req_ready !== 1'b1 || mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_second_accept: stall=%b ready=%b mem_en=%b, expected 0/1/0", stall, req_ready, mem_en);
      end
      step();
      idle_req();
      wait_mem_en("b2b_drain2_start");
      vectors++;
      if (mem_wr !== 1'b1 || mem_addr !== 16'h0008 || mem_wdata !== 16'h2222) begin
         miscompares++;
         $display("FAIL b2b_drain2: wr=%b addr=%h wdata=%h, expected 1/0008/2222", mem_wr, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      #1;
      vectors++;
      if (mem_en !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_done: mem_en=%b, expected 0", mem_en);
      end
   endtask

   initial begin
      test_reset();
      test_store_drain();
      test_forward();
      test_load_miss();
      test_drain_then_load();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
